// File: rtl/switch_debounce4.sv
// switch_debounce4: four-channel switch conditioner.
// Each raw switch input passes through a two-flop synchronizer. It is then
// debounced by a per-channel stability counter, so that only levels held for
// DEBOUNCE_CYCLES synchronized cycles reach the a/b/c/d outputs.
// A one-cycle chg strobe marks each accepted transition, and settled reports
// that no channel has a pending disagreement.
module switch_debounce4 #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] chg,
  output logic       settled
);

  // Counter value at which a persisting new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       out_q;
  logic [3:0]       out_d;
  logic [3:0]       chg_q;
  logic [3:0]       chg_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Per-channel debounce decision: hold, count toward acceptance, or accept.
  always_comb begin
    out_d = out_q;
    chg_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == out_q[i]) begin
        // Input agrees with the output; any partial progress is discarded.
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        // New level has persisted long enough: accept it and strobe.
        out_d[i] = sync2_q[i];
        chg_d[i] = 1'b1;
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Synchronizer chain, stability counters, debounced levels and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      out_q   <= 4'b0000;
      chg_q   <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      chg_q   <= chg_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign a       = out_q[3];
  assign b       = out_q[2];
  assign c       = out_q[1];
  assign d       = out_q[0];
  assign chg     = chg_q;
  // Every channel's synchronized input matches its debounced output.
  assign settled = &(~(sync2_q ^ out_q));

endmodule

// File: doc/switch_debounce4.md
# switch_debounce4

Four-channel input conditioner that sits directly upstream of the and4gate stage. It takes four raw, asynchronous, bouncing switch inputs, synchronizes each into the clock domain, and debounces each independently. It drives clean, glitch-free a/b/c/d levels into the gate, plus per-channel change strobes and a settled flag for downstream logic.

## Interface
- DEBOUNCE_CYCLES, 50000: number of consecutive synchronized cycles a new level must persist before it is accepted. Must be ≥ 2 and ≤ 2^CNT_W.
- CNT_W, 16: width of each per-channel stability counter.

- clk  in  1  single system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- sw_in  in  4  raw switch levels, asynchronous to clk; bit 3→a, 2→b, 1→c, 0→d
- a  out  1  debounced level of sw_in[3]
- b  out  1  debounced level of sw_in[2]
- c  out  1  debounced level of sw_in[1]
- d  out  1  debounced level of sw_in[0]
- chg  out  4  one-cycle strobe per channel (same bit order as sw_in), high in the cycle its debounced output changed
- settled  out  1  high when every channel's synchronized input equals its debounced output

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Per channel, a 2-flop synchronizer (sync1 → sync2) feeds the debouncer. The debouncer compares sync2 with the registered output.
- If sync2 equals the output:
  - counter ← 0
  - output holds
- If sync2 differs from the output and counter ≠ DEBOUNCE_CYCLES−1:
  - counter ← counter+1
- If sync2 differs from the output and counter = DEBOUNCE_CYCLES−1:
  - output ← sync2
  - counter ← 0
  - chg bit ← 1 for exactly that cycle
- Any return of sync2 to the current output level before acceptance clears the counter. Pulses shorter than DEBOUNCE_CYCLES synchronized cycles never reach a–d.
- The counter never exceeds DEBOUNCE_CYCLES−1 and never wraps.
- Channels are fully independent. Simultaneous transitions on several channels are each accepted on their own schedule; several chg bits may be high in the same cycle.
- settled is combinational from registered state: AND over channels of (sync2 == output).

## Timing
- Reset values (asserted asynchronously, immediately on rst_n low):
  - sync1, sync2, counters: 0
  - a, b, c, d: 0
  - chg: 4'b0000
  - settled: 1
- Reset mid-count discards all progress. After rst_n deasserts, a held-high switch is re-accepted from scratch.
- Latency:
  - Let edge 0 be the first rising edge that samples a new sw_in level held stable.
  - sync2 shows it after edge 1.
  - The output and chg update on edge DEBOUNCE_CYCLES+1, i.e. the (DEBOUNCE_CYCLES+2)th edge.
  - chg falls on the next edge.
- settled:
  - deasserts one cycle after sync2 diverges (after edge 1)
  - reasserts in the same cycle the output updates
  - reasserts immediately if sync2 reverts early
- Outputs a–d are registered with no combinational path from sw_in. They change only coincident with their chg bit.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: drive rst_n=0 mid-simulation with sw_in=4'hF and outputs high → a–d=0, chg=0, settled=1 immediately, without waiting for a clock edge.
- Clean press: sw_in 4'h0→4'h8, held → a=1 and chg=4'b1000 on edge 5 after the sampling edge, chg=0 on edge 6, b/c/d stay 0, settled low for edges 1–4.
- Bounce rejection: toggle sw_in[0] high for 3 cycles, low for 1, high for 3, then low → d never rises, chg[0] never pulses, settled returns to 1.
- Simultaneous channels: sw_in 4'h0→4'hF in one cycle → a=b=c=d=1 and chg=4'hF on the same edge. With all four high, the downstream and4gate output f=1 one cycle later.
- Staggered release: from 4'hF, clear sw_in[3], then sw_in[1] two cycles later → a falls, then c falls exactly 2 cycles after a, each with its own single chg pulse.
- Reset mid-count: assert rst_n low at counter=2 during a rising transition on sw_in[2], release with sw_in[2] still high → b rises DEBOUNCE_CYCLES+2 edges after the first post-reset edge, not earlier.
